// File: rtl/muldiv_pkg.sv
// Shared constants, op encodings and FSM state type for the multiply/divide unit.
// Divide support is compiled in only when MULDIV_DIV_EN is defined.
package muldiv_pkg;

    localparam int DATA_W       = 32;
    localparam int MULDIV_ITERS = 32;
    localparam int CNT_W        = $clog2(MULDIV_ITERS);

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_MUL  = 2'b01,
        S_DIV  = 2'b10,
        S_FIX  = 2'b11
    } state_t;

endpackage

// File: rtl/muldiv_core.sv
// Iterative shift-add multiplier / restoring divider sharing one 64-bit shift register.
// Divider datapath present only when MULDIV_DIV_EN is defined.
module muldiv_core
    import muldiv_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load,
    input  logic              i_step,
    input  op_t               i_op,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_hi,
    output logic [DATA_W-1:0] o_lo,
    output logic              o_div_zero
);

    logic [2*DATA_W-1:0] r_acc;
    logic [DATA_W-1:0]   r_mcand;
    logic                r_neg_res;

    logic                w_signed;
    logic                w_a_neg;
    logic                w_b_neg;
    logic                w_is_div;
    logic [DATA_W-1:0]   w_a_mag;
    logic [DATA_W-1:0]   w_b_mag;
    logic [DATA_W:0]     w_sum;
    logic [2*DATA_W-1:0] w_next;
    logic [2*DATA_W-1:0] w_prod;

    assign w_signed = (i_op == OP_MULT) || (i_op == OP_DIV);
    assign w_a_neg  = w_signed & i_a[DATA_W-1];
    assign w_b_neg  = w_signed & i_b[DATA_W-1];
    assign w_a_mag  = w_a_neg ? -i_a : i_a;
    assign w_b_mag  = w_b_neg ? -i_b : i_b;
    assign w_prod   = r_neg_res ? -r_acc : r_acc;

`ifdef MULDIV_DIV_EN
    logic              r_is_div;
    logic              r_neg_rem;
    logic              r_b_zero;
    logic [DATA_W:0]   w_trial;
    logic [DATA_W-1:0] w_quot;
    logic [DATA_W-1:0] w_rem;

    assign w_is_div = i_op[1];
`else
    assign w_is_div = 1'b0;
`endif

    // Multiply: add multiplicand into upper half on LSB, shift right.
    // Divide: upper half is the remainder, lower half shifts dividend out / quotient in.
    always_comb begin
        w_sum  = {1'b0, r_acc[2*DATA_W-1:DATA_W]} + (r_acc[0] ? {1'b0, r_mcand} : '0);
        w_next = {w_sum, r_acc[DATA_W-1:1]};
`ifdef MULDIV_DIV_EN
        w_trial = r_acc[2*DATA_W-1:DATA_W-1] - {1'b0, r_mcand};
        if (r_is_div) begin
            if (w_trial[DATA_W]) begin
                w_next = {r_acc[2*DATA_W-2:0], 1'b0};
            end else begin
                w_next = {w_trial[DATA_W-1:0], r_acc[DATA_W-2:0], 1'b1};
            end
        end
`endif
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc     <= '0;
            r_mcand   <= '0;
            r_neg_res <= 1'b0;
`ifdef MULDIV_DIV_EN
            r_is_div  <= 1'b0;
            r_neg_rem <= 1'b0;
            r_b_zero  <= 1'b0;
`endif
        end else if (i_load) begin
            r_acc     <= {{DATA_W{1'b0}}, (w_is_div ? w_a_mag : w_b_mag)};
            r_mcand   <= w_is_div ? w_b_mag : w_a_mag;
            r_neg_res <= w_a_neg ^ w_b_neg;
`ifdef MULDIV_DIV_EN
            r_is_div  <= w_is_div;
            r_neg_rem <= w_a_neg;
            r_b_zero  <= (i_b == '0);
`endif
        end else if (i_step) begin
            r_acc <= w_next;
        end
    end

`ifdef MULDIV_DIV_EN
    // Divide by zero leaves quotient all-ones; remainder re-signed back to A.
    assign w_quot     = r_b_zero ? '1 : (r_neg_res ? -r_acc[DATA_W-1:0] : r_acc[DATA_W-1:0]);
    assign w_rem      = r_neg_rem ? -r_acc[2*DATA_W-1:DATA_W] : r_acc[2*DATA_W-1:DATA_W];
    assign o_hi       = r_is_div ? w_rem  : w_prod[2*DATA_W-1:DATA_W];
    assign o_lo       = r_is_div ? w_quot : w_prod[DATA_W-1:0];
    assign o_div_zero = r_is_div & r_b_zero;
`else
    assign o_hi       = w_prod[2*DATA_W-1:DATA_W];
    assign o_lo       = w_prod[DATA_W-1:0];
    assign o_div_zero = 1'b0;
`endif

endmodule

// File: rtl/muldiv_ctrl.sv
// EX-stage multiply/divide controller: sequencing FSM, HI/LO registers and hazard stall.
// Define MULDIV_DIV_EN to enable DIV/DIVU; otherwise divide ops are ignored.
module muldiv_ctrl
    import muldiv_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              StartE,
    input  logic [1:0]        MulDivOpE,
    input  logic [DATA_W-1:0] SrcAE,
    input  logic [DATA_W-1:0] SrcBE,
    input  logic [1:0]        HiLoWrE,
    input  logic [DATA_W-1:0] WriteDataE,
    input  logic              HiLoRdE,
    input  logic              HiLoSelE,
    output logic [DATA_W-1:0] HiLoOutE,
    output logic              Busy,
    output logic              StallE,
    output logic              DivZero
);

    // state  | meaning
    // S_IDLE | waiting; accepts StartE and MTHI/MTLO
    // S_MUL  | shift-add iterations
    // S_DIV  | restoring-divide iterations
    // S_FIX  | sign correction, HI/LO commit
    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_hi;
    logic [DATA_W-1:0] r_lo;

    logic              w_accept;
    logic              w_start_div;
    logic              w_step;
    logic              w_cnt_tc;
    logic [DATA_W-1:0] w_core_hi;
    logic [DATA_W-1:0] w_core_lo;
    logic              w_core_div_zero;

`ifdef MULDIV_DIV_EN
    assign w_start_div = MulDivOpE[1];
    assign w_accept    = (r_state == S_IDLE) & StartE;
`else
    assign w_start_div = 1'b0;
    assign w_accept    = (r_state == S_IDLE) & StartE & ~MulDivOpE[1];
`endif

    assign w_step   = (r_state == S_MUL) || (r_state == S_DIV);
    assign w_cnt_tc = (r_cnt == CNT_W'(MULDIV_ITERS - 1));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:       if (w_accept) w_state_nxt = w_start_div ? S_DIV : S_MUL;
            S_MUL, S_DIV: if (w_cnt_tc) w_state_nxt = S_FIX;
            S_FIX:        w_state_nxt = S_IDLE;
            default:      w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_cnt <= '0;
            end else if (w_step) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // A same-cycle StartE takes priority over MTHI/MTLO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (r_state == S_FIX) begin
            r_hi <= w_core_hi;
            r_lo <= w_core_lo;
        end else if ((r_state == S_IDLE) && !StartE) begin
            if (HiLoWrE[1]) r_hi <= WriteDataE;
            if (HiLoWrE[0]) r_lo <= WriteDataE;
        end
    end

    muldiv_core u_core (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_load     (w_accept),
        .i_step     (w_step),
        .i_op       (op_t'(MulDivOpE)),
        .i_a        (SrcAE),
        .i_b        (SrcBE),
        .o_hi       (w_core_hi),
        .o_lo       (w_core_lo),
        .o_div_zero (w_core_div_zero)
    );

    assign HiLoOutE = HiLoSelE ? r_hi : r_lo;
    assign Busy     = (r_state != S_IDLE);
    assign StallE   = Busy & (StartE | HiLoRdE | (HiLoWrE != 2'b00));
    assign DivZero  = (r_state == S_FIX) & w_core_div_zero;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed vector table, corner sequences, random ops vs arithmetic model.
module tb_muldiv_ctrl;

`ifdef MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        StartE;
    logic [1:0]  MulDivOpE;
    logic [31:0] SrcAE;
    logic [31:0] SrcBE;
    logic [1:0]  HiLoWrE;
    logic [31:0] WriteDataE;
    logic        HiLoRdE;
    logic        HiLoSelE;
    logic [31:0] HiLoOutE;
    logic        Busy;
    logic        StallE;
    logic        DivZero;

    int errors = 0;
    int checks = 0;

    logic [31:0] m_hi;
    logic [31:0] m_lo;

    muldiv_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .StartE     (StartE),
        .MulDivOpE  (MulDivOpE),
        .SrcAE      (SrcAE),
        .SrcBE      (SrcBE),
        .HiLoWrE    (HiLoWrE),
        .WriteDataE (WriteDataE),
        .HiLoRdE    (HiLoRdE),
        .HiLoSelE   (HiLoSelE),
        .HiLoOutE   (HiLoOutE),
        .Busy       (Busy),
        .StallE     (StallE),
        .DivZero    (DivZero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        bit          dz;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
        HiLoSelE = 1'b1;
        #1 hi = HiLoOutE;
        HiLoSelE = 1'b0;
        #1 lo = HiLoOutE;
    endtask

    // Reference: plain signed/unsigned arithmetic with the architectural special cases.
    task automatic ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                             output logic [31:0] hi, output logic [31:0] lo,
                             output bit dz, output int cyc);
        int          sa;
        int          sb;
        longint      sp;
        logic [63:0] up;
        sa  = a;
        sb  = b;
        hi  = m_hi;
        lo  = m_lo;
        dz  = 1'b0;
        cyc = 33;
        case (op)
            2'b00: begin
                sp = longint'(sa) * longint'(sb);
                {hi, lo} = sp;
            end
            2'b01: begin
                up = {32'd0, a} * {32'd0, b};
                {hi, lo} = up;
            end
            default: begin
                if (!DIV_EN) begin
                    cyc = 0;
                end else if (b == 32'd0) begin
                    hi = a;
                    lo = 32'hFFFF_FFFF;
                    dz = 1'b1;
                end else if (op == 2'b10 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    hi = 32'd0;
                    lo = 32'h8000_0000;
                end else if (op == 2'b10) begin
                    lo = sa / sb;
                    hi = sa % sb;
                end else begin
                    lo = a / b;
                    hi = a % b;
                end
            end
        endcase
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo, input bit edz,
                          input int ecyc, input string nm);
        int          n;
        int          dzn;
        int          dzpos;
        bit          moved;
        logic [31:0] lo_before;
        logic [31:0] ahi;
        logic [31:0] alo;
        HiLoSelE  = 1'b0;
        #1 lo_before = HiLoOutE;
        StartE    = 1'b1;
        MulDivOpE = op;
        SrcAE     = a;
        SrcBE     = b;
        tick();
        StartE  = 1'b0;
        HiLoWrE = 2'b00;
        n = 0; dzn = 0; dzpos = -1; moved = 1'b0;
        #1;
        while (Busy && n < 100) begin
            if (DivZero) begin dzn++; dzpos = n; end
            if (HiLoOutE !== lo_before) moved = 1'b1;
            tick();
            n++;
        end
        check({nm, " busy_cycles"}, n, ecyc);
        check({nm, " divzero_pulses"}, dzn, edz ? 1 : 0);
        if (edz) check({nm, " divzero_in_fix"}, dzpos, 32);
        check({nm, " lo_no_partial"}, moved, 1'b0);
        check({nm, " divzero_after"}, DivZero, 1'b0);
        read_hilo(ahi, alo);
        check({nm, " hi"}, ahi, ehi);
        check({nm, " lo"}, alo, elo);
        m_hi = ehi;
        m_lo = elo;
    endtask

    initial begin
        logic [31:0] ehi;
        logic [31:0] elo;
        logic [31:0] ahi;
        logic [31:0] alo;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [1:0]  rop;
        bit          edz;
        int          ecyc;
        int          n;
        int          stall_n;

        vecs[0] = '{2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0};
        vecs[1] = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
        vecs[2] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[3] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
        vecs[4] = '{2'b11, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF, 1'b1};
        vecs[5] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
        vecs[6] = '{2'b11, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF, 1'b0};
        vecs[7] = '{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
        vecs[8] = '{2'b10, 32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1};
        vecs[9] = '{2'b01, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0};

        rst_n = 1'b0; StartE = 1'b0; MulDivOpE = 2'b00; SrcAE = '0; SrcBE = '0;
        HiLoWrE = 2'b00; WriteDataE = '0; HiLoRdE = 1'b0; HiLoSelE = 1'b0;
        m_hi = '0; m_lo = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", Busy, 1'b0);
        check("reset stall", StallE, 1'b0);
        check("reset divzero", DivZero, 1'b0);
        read_hilo(ahi, alo);
        check("reset hi", ahi, 32'd0);
        check("reset lo", alo, 32'd0);
        rst_n = 1'b1;
        tick();

        // MTLO / MTHI while idle
        HiLoWrE = 2'b01; WriteDataE = 32'h0000_1234;
        tick();
        HiLoWrE = 2'b10; WriteDataE = 32'h0000_5678;
        #1 check("mtlo lo", HiLoOutE, 32'h0000_1234);
        tick();
        HiLoWrE = 2'b00;
        read_hilo(ahi, alo);
        check("mthi hi", ahi, 32'h0000_5678);
        check("mthi keeps lo", alo, 32'h0000_1234);
        m_hi = ahi; m_lo = alo;

        // Directed vector table
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].op[1] && !DIV_EN) begin
                run_op(vecs[i].op, vecs[i].a, vecs[i].b, m_hi, m_lo, 1'b0, 0, $sformatf("vec%0d", i));
            end else begin
                run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].dz, 33,
                       $sformatf("vec%0d", i));
            end
        end

        // StartE with MTLO in the same cycle: write dropped, product committed
        HiLoWrE = 2'b01; WriteDataE = 32'hDEAD_BEEF;
        run_op(2'b01, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 33, "start_wins");

        // MFLO during busy stalls until commit; a re-presented StartE is not accepted
        HiLoSelE = 1'b0;
        StartE = 1'b1; MulDivOpE = 2'b00; SrcAE = 32'hFFFF_FFFD; SrcBE = 32'h0000_0005;
        tick();
        StartE = 1'b0;
        n = 0; stall_n = 0;
        while (Busy && n < 100) begin
            if (n == 4) HiLoRdE = 1'b1;
            if (n == 10) begin StartE = 1'b1; MulDivOpE = 2'b01; SrcAE = 32'd9; SrcBE = 32'd9; end
            if (n == 11) StartE = 1'b0;
            #1;
            if (StallE) stall_n++;
            if (n == 6) check("stall lo committed", HiLoOutE, 32'd42);
            tick();
            n++;
        end
        check("stall busy_cycles", n, 33);
        check("stall cycles", stall_n, 29);
        check("stall released", StallE, 1'b0);
        check("stall new lo", HiLoOutE, 32'hFFFF_FFF1);
        HiLoRdE = 1'b0;
        tick();
        check("stalled start ignored", Busy, 1'b0);
        m_hi = 32'hFFFF_FFFF; m_lo = 32'hFFFF_FFF1;

        // Reset mid-operation
        StartE = 1'b1; MulDivOpE = 2'b00; SrcAE = 32'd3; SrcBE = 32'd5;
        tick();
        StartE = 1'b0;
        repeat (9) tick();
        rst_n = 1'b0;
        #1;
        check("abort busy", Busy, 1'b0);
        read_hilo(ahi, alo);
        check("abort hi", ahi, 32'd0);
        check("abort lo", alo, 32'd0);
        tick();
        rst_n = 1'b1;
        m_hi = '0; m_lo = '0;
        tick();
        run_op(2'b00, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, 33, "after_abort");

        // Randomized ops against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = 32'($urandom_range(1, 20));
                3: ra = 32'h8000_0000;
                default: ;
            endcase
            ref_model(rop, ra, rb, ehi, elo, edz, ecyc);
            run_op(rop, ra, rb, ehi, elo, edz, ecyc, $sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Sequential multiply/divide controller for the EX stage of the pipelined CPU. It accepts MULT/MULTU/DIV/DIVU operands from the E-stage operand muxes, runs a fixed-latency iterative shift-add or restoring-divide sequence, and owns the architectural HI/LO registers. It raises a stall to the hazard unit whenever a later instruction touches HI/LO or issues a new op while the unit is busy.

## Interface
Parameters:
- none; widths and latency are constants in the shared package.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- StartE  in  1  E-stage instruction is MULT/MULTU/DIV/DIVU
- MulDivOpE  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- SrcAE  in  32  operand A / dividend
- SrcBE  in  32  operand B / divisor
- HiLoWrE  in  2  bit1 MTHI, bit0 MTLO
- WriteDataE  in  32  data for MTHI/MTLO
- HiLoRdE  in  1  E-stage instruction is MFHI/MFLO
- HiLoSelE  in  1  0 = LO, 1 = HI
- HiLoOutE  out  32  combinational read of selected HI/LO register
- Busy  out  1  sequence in progress
- StallE  out  1  stall request to hazard unit
- DivZero  out  1  one-cycle pulse: divide by zero completed

## Operation
- FSM states: IDLE, MUL, DIV, FIX.
- IDLE + StartE: latch |operands| (signed ops) or raw operands (unsigned), latch op and result signs, iteration counter = 0; go to MUL (ops 0x) or DIV (ops 1x).
- MUL: one shift-add step per cycle, 64-bit accumulator; 32 cycles, then FIX.
- DIV: one restoring step per cycle, 32-bit remainder / quotient shift; 32 cycles, then FIX.
- FIX: apply sign correction (two's complement negate); write HI/LO; return to IDLE. Unsigned ops pass through FIX unchanged (fixed latency).
- Signed divide: quotient sign = sign(A) xor sign(B); remainder sign = sign(A).
- Divide by zero (B == 0): LO = 0xFFFFFFFF, HI = A (unsigned or signed, no sign fix); DivZero pulses during the FIX cycle.
- 0x80000000 / -1 (DIV): LO = 0x80000000, HI = 0.
- MTHI/MTLO in IDLE: write WriteDataE at the next edge. StartE and HiLoWrE in the same cycle: StartE wins, write dropped.
- HiLoOutE always reflects the committed registers; it never shows partial results.
- StallE = Busy & (StartE | HiLoRdE | HiLoWrE != 0). Stalled requests are not accepted; the pipeline re-presents them.

## Timing
- Reset: state IDLE; HI = LO = 0; Busy = 0; StallE = 0; DivZero = 0; counter = 0.
- StartE sampled at edge T0: Busy = 1 for cycles T0+1 through T0+33 (32 iterate + 1 FIX).
- HI/LO are updated at edge T0+33. Busy = 0 and the new HiLoOutE are visible from then.
- Back-to-back: a new StartE is accepted at the first edge where Busy was 0.
- Counter wraps 31 -> 0 on the final iteration; no other wrap behaviour.
- Reset asserted mid-operation aborts immediately: the result is discarded and all registers are reset.

## Configuration
- MULDIV_DIV_EN defined: DIV/DIVU supported as above.
- Not defined: DIV state, divider datapath and DivZero logic are removed. DivZero is tied 0. StartE with op 1x is ignored: no Busy, HI/LO unchanged. Multiply behaviour is identical.

## Structure
- Package muldiv_pkg:
  - op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU)
  - FSM state enum
  - MULDIV_ITERS = 32
  - DATA_W = 32
- Sub-module muldiv_core: the iterative datapath (accumulator, remainder, quotient shift registers, negate). muldiv_ctrl keeps the FSM, counter, HI/LO and the stall logic.

## Test plan
- MULTU 0xFFFFFFFF × 0x00000002 -> HI = 0x00000001, LO = 0xFFFFFFFE at T0+33; Busy high exactly 33 cycles.
- MULT 0xFFFFFFFD (-3) × 0x00000005 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFF1.
- DIV 0xFFFFFFF9 (-7) / 0x00000002 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> LO = 0x80000000, HI = 0.
- DIVU 0x00000005 / 0 -> LO = 0xFFFFFFFF, HI = 0x00000005; DivZero is high for exactly one cycle at T0+33.
- HiLoRdE = 1 at T0+5 with HiLoSelE = 0 -> StallE = 1 through T0+33; then HiLoOutE shows the new LO. MTLO 0x00001234 while idle -> LO = 0x00001234 next cycle.
- rst_n low at T0+10 of a MULT -> Busy = 0, HI = LO = 0 immediately; a new StartE after release completes normally.
